// File: rtl/debug_display_scan_if.sv
// Bundles the debug-display front-end signals; the testbench (master) drives
// the channel data and switches, and the scanner (slave) returns display outputs.
interface debug_display_scan_if #(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int VAL_W  = 8
);
  localparam int DIGITS = 2 * VAL_W / 4;

  logic [NUM_CH*2*VAL_W-1:0] ch_data;
  logic [SEL_W-1:0]          sel;
  logic                      auto_mode;
  logic                      step_btn;
  logic                      step_pulse;
  logic [SEL_W-1:0]          cur_ch;
  logic [DIGITS-1:0]         an;
  logic [7:0]                seg;

  modport master (
    output ch_data, sel, auto_mode, step_btn,
    input  step_pulse, cur_ch, an, seg
  );

  modport slave (
    input  ch_data, sel, auto_mode, step_btn,
    output step_pulse, cur_ch, an, seg
  );
endinterface

// File: rtl/debug_display_scan.sv
// Debug display scanner: multiplexes channel value pairs onto an active-low
// 7-segment display. A frame-coherent snapshot prevents tearing, auto mode
// cycles the channels, and a debouncer turns the step button into a pulse.
module debug_display_scan #(
  parameter int NUM_CH       = 4,
  parameter int SEL_W        = 2,
  parameter int VAL_W        = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int AUTO_FRAMES  = 500,
  parameter int DEBOUNCE_CYC = 1000000
) (
  input  logic                 clock,
  input  logic                 Reset,
  debug_display_scan_if.slave  bus
);
  localparam int DIGITS = 2 * VAL_W / 4;
  localparam int CH_W   = 2 * VAL_W;
  localparam int RW     = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
  localparam int DW     = (DIGITS       > 1) ? $clog2(DIGITS)       : 1;
  localparam int FW     = (AUTO_FRAMES  > 1) ? $clog2(AUTO_FRAMES)  : 1;
  localparam int BW     = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [RW-1:0]     refresh_cnt;
  logic [DW-1:0]     digit_idx;
  logic              refresh_tc;
  logic              frame_bnd;
  logic [FW-1:0]     frame_cnt;
  logic [FW-1:0]     frame_next;
  logic [SEL_W-1:0]  cur_ch;
  logic [SEL_W-1:0]  ch_next;
  logic              auto_prev;
  logic              auto_rise;
  logic [CH_W-1:0]   snapshot;
  logic [CH_W-1:0]   ch_arr  [NUM_CH];
  logic [3:0]        nib_arr [DIGITS];
  logic [DIGITS-1:0] an_reg;
  logic [7:0]        seg_reg;
  logic [7:0]        seg_next;
  logic              sync1;
  logic              sync2;
  logic              stable;
  logic              stable_prev;
  logic              pulse_reg;
  logic [BW-1:0]     db_cnt;

  // Slice the flat channel bus and the snapshot into indexable pieces.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_arr[gi] = bus.ch_data[gi*CH_W +: CH_W];
  end
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign nib_arr[gi] = snapshot[gi*4 +: 4];
  end

  assign refresh_tc = (refresh_cnt == RW'(REFRESH_DIV - 1));
  assign frame_bnd  = refresh_tc && (digit_idx == DW'(DIGITS - 1));
  assign auto_rise  = bus.auto_mode && !auto_prev;

  // Active-low hex font with the decimal point off.
  function automatic logic [7:0] hex_code(input logic [3:0] v);
    case (v)
      4'h0: hex_code = 8'hC0;  4'h1: hex_code = 8'hF9;
      4'h2: hex_code = 8'hA4;  4'h3: hex_code = 8'hB0;
      4'h4: hex_code = 8'h99;  4'h5: hex_code = 8'h92;
      4'h6: hex_code = 8'h82;  4'h7: hex_code = 8'hF8;
      4'h8: hex_code = 8'h80;  4'h9: hex_code = 8'h90;
      4'hA: hex_code = 8'h88;  4'hB: hex_code = 8'h83;
      4'hC: hex_code = 8'hC6;  4'hD: hex_code = 8'hA1;
      4'hE: hex_code = 8'h86;  default: hex_code = 8'h8E;
    endcase
  endfunction

  // Refresh divider and digit scan position.
  always_ff @(posedge clock) begin
    if (Reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
    end else if (refresh_tc) begin
      refresh_cnt <= '0;
      digit_idx   <= (digit_idx == DW'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Channel choice at frame boundaries; the auto advance is decided before the snapshot loads.
  always_comb begin
    ch_next    = cur_ch;
    frame_next = frame_cnt;
    if (auto_rise) begin
      frame_next = '0;
    end else if (bus.auto_mode && frame_bnd) begin
      if (frame_cnt == FW'(AUTO_FRAMES - 1)) begin
        frame_next = '0;
        ch_next    = (cur_ch == SEL_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
      end else begin
        frame_next = frame_cnt + 1'b1;
      end
    end else if (!bus.auto_mode && frame_bnd && (int'(bus.sel) < NUM_CH)) begin
      ch_next = bus.sel;
    end
  end

  // Channel, frame counter and snapshot registers; snapshot only reloads on a boundary.
  always_ff @(posedge clock) begin
    if (Reset) begin
      cur_ch    <= '0;
      frame_cnt <= '0;
      auto_prev <= 1'b0;
      snapshot  <= '0;
    end else begin
      cur_ch    <= ch_next;
      frame_cnt <= frame_next;
      auto_prev <= bus.auto_mode;
      if (frame_bnd) begin
        snapshot <= ch_arr[ch_next];
      end
    end
  end

  // Segment pattern for the digit being scanned; dp lights between in1 and in2.
  always_comb begin
    seg_next = hex_code(nib_arr[digit_idx]);
    if (digit_idx == DW'(DIGITS / 2)) begin
      seg_next[7] = 1'b0;
    end
  end

  // Registered display outputs, one cycle behind digit_idx.
  always_ff @(posedge clock) begin
    if (Reset) begin
      an_reg  <= '1;
      seg_reg <= 8'hFF;
    end else begin
      an_reg  <= ~(DIGITS'(1) << digit_idx);
      seg_reg <= seg_next;
    end
  end

  // Step button: two-flop synchroniser, stability counter, rising-edge pulse.
  always_ff @(posedge clock) begin
    if (Reset) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      stable      <= 1'b0;
      stable_prev <= 1'b0;
      pulse_reg   <= 1'b0;
      db_cnt      <= '0;
    end else begin
      sync1       <= bus.step_btn;
      sync2       <= sync1;
      stable_prev <= stable;
      pulse_reg   <= stable && !stable_prev;
      if (sync2 != stable) begin
        if (db_cnt == BW'(DEBOUNCE_CYC - 1)) begin
          stable <= sync2;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign bus.an         = an_reg;
  assign bus.seg        = seg_reg;
  assign bus.cur_ch     = cur_ch;
  assign bus.step_pulse = pulse_reg;
endmodule

// File: tb/tb_debug_display_scan.sv
// Self-checking bench for debug_display_scan: hand sequences, a vector table
// and randomized traffic compared every cycle with a behavioural model.
module tb_debug_display_scan;
  localparam int R     = 4;
  localparam int AF    = 2;
  localparam int DB    = 8;
  localparam int FRAME = R * 4;

  logic clock = 1'b0;
  logic Reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  debug_display_scan_if #(.NUM_CH(4), .SEL_W(2), .VAL_W(8)) if1 ();
  debug_display_scan_if #(.NUM_CH(3), .SEL_W(2), .VAL_W(8)) if3 ();

  debug_display_scan #(.NUM_CH(4), .SEL_W(2), .VAL_W(8), .REFRESH_DIV(R),
                       .AUTO_FRAMES(AF), .DEBOUNCE_CYC(DB))
    dut (.clock(clock), .Reset(Reset), .bus(if1));

  debug_display_scan #(.NUM_CH(3), .SEL_W(2), .VAL_W(8), .REFRESH_DIV(R),
                       .AUTO_FRAMES(AF), .DEBOUNCE_CYC(DB))
    dut3 (.clock(clock), .Reset(Reset), .bus(if3));

  always #5 clock = ~clock;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Behavioural model state: n = clock edges since reset released.
  int         n;
  int         m_frames;
  int         m_run;
  logic [1:0] m_ch;
  logic [15:0] m_snap;
  logic       m_auto_prev, m_b1, m_b2, m_stable, m_rose;
  logic [3:0] exp_an;
  logic [7:0] exp_seg;
  logic [1:0] exp_ch;
  logic       exp_pulse;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] data;
    logic [31:0] segs;   // byte k = expected seg of digit k
  } vec_t;
  vec_t vec [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, n, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int d;
    if (Reset) begin
      n = 0; m_frames = 0; m_run = 0; m_ch = 0; m_snap = 0;
      m_auto_prev = 0; m_b1 = 0; m_b2 = 0; m_stable = 0; m_rose = 0;
      exp_an = 4'hF; exp_seg = 8'hFF; exp_pulse = 0;
    end else begin
      d = (n / R) % 4;
      exp_an  = ~(4'b0001 << d);
      exp_seg = hex_tab[m_snap[d*4 +: 4]] & ((d == 2) ? 8'h7F : 8'hFF);
      n++;
      if (if1.auto_mode && !m_auto_prev) begin
        m_frames = 0;
      end else if (n % FRAME == 0) begin
        if (if1.auto_mode) begin
          m_frames++;
          if (m_frames == AF) begin
            m_frames = 0;
            m_ch = 2'((m_ch + 1) % 4);
          end
        end else begin
          m_ch = if1.sel;   // every select value is a valid channel with four channels
        end
      end
      if (n % FRAME == 0) m_snap = if1.ch_data[m_ch*16 +: 16];
      m_auto_prev = if1.auto_mode;
      exp_pulse = m_rose;
      m_rose = 0;
      if (m_b2 != m_stable) begin
        m_run++;
        if (m_run == DB) begin
          m_stable = m_b2;
          m_run = 0;
          m_rose = m_stable;
        end
      end else begin
        m_run = 0;
      end
      m_b2 = m_b1;
      m_b1 = if1.step_btn;
    end
    exp_ch = m_ch;
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check("model_an",    32'(if1.an),         32'(exp_an));
    check("model_seg",   32'(if1.seg),        32'(exp_seg));
    check("model_cur",   32'(if1.cur_ch),     32'(exp_ch));
    check("model_pulse", 32'(if1.step_pulse), 32'(exp_pulse));
  endtask

  task automatic wait_boundary();
    int k;
    k = 0;
    do begin
      tick();
      k++;
    end while ((n % FRAME != 0) && (k < 64));
    if (n % FRAME != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL boundary_wait: no frame boundary within %0d cycles", k);
    end
  endtask

  task automatic set_ch(input int c, input logic [15:0] v);
    if1.ch_data[c*16 +: 16] = v;
  endtask

  initial begin
    logic [3:0]  an_pat [4];
    logic [31:0] old_segs, new_segs;
    an_pat = '{4'hE, 4'hD, 4'hB, 4'h7};
    old_segs = 32'hB008F88E;
    new_segs = 32'hF924B099;
    vec[0] = '{2'd2, 16'h3A7F, 32'hB008F88E};
    vec[1] = '{2'd0, 16'h0123, 32'hC079A4B0};
    vec[2] = '{2'd1, 16'h4567, 32'h991282F8};
    vec[3] = '{2'd3, 16'h89AB, 32'h80108883};
    vec[4] = '{2'd2, 16'hCDEF, 32'hC621868E};

    if1.ch_data = '0; if1.sel = 0; if1.auto_mode = 0; if1.step_btn = 0;
    if3.ch_data = '0; if3.sel = 2; if3.auto_mode = 0; if3.step_btn = 0;

    // Reset state and scan pattern with all-zero data.
    repeat (3) tick();
    check("reset_an",  32'(if1.an),  32'hF);
    check("reset_seg", 32'(if1.seg), 32'hFF);
    check("reset_cur", 32'(if1.cur_ch), 32'h0);
    Reset = 0;
    for (int k = 0; k < 32; k++) begin
      tick();
      check("scan_an",  32'(if1.an),  32'(an_pat[(k / 4) % 4]));
      check("scan_seg", 32'(if1.seg), ((k / 4) % 4 == 2) ? 32'h40 : 32'hC0);
    end
    $display("reset scan: 32 cycles checked");

    // Manual selection table; sel changes mid-frame must not disturb the display.
    for (int i = 0; i < 5; i++) begin
      if1.sel = vec[i].sel;
      set_ch(int'(vec[i].sel), vec[i].data);
      wait_boundary();
      check("vec_cur", 32'(if1.cur_ch), 32'(vec[i].sel));
      for (int t = 1; t <= FRAME; t++) begin
        tick();
        if ((t - 1) % R == 0) check("vec_seg", 32'(if1.seg), 32'(vec[i].segs[((t-1)/R)*8 +: 8]));
        if (t == 6) if1.sel = vec[i].sel ^ 2'd1;
      end
      $display("vector %0d: ch%0d=%h segs=%h", i, vec[i].sel, vec[i].data, vec[i].segs);
    end

    // Tearing: data changes during digit 1 only appear in the following frame.
    if1.sel = 2;
    set_ch(2, 16'h3A7F);
    wait_boundary();
    for (int t = 1; t <= FRAME; t++) begin
      tick();
      if ((t - 1) % R == 0) check("tear_old", 32'(if1.seg), 32'(old_segs[((t-1)/R)*8 +: 8]));
      if (t == 5) set_ch(2, 16'h1234);
    end
    for (int t = 1; t <= FRAME; t++) begin
      tick();
      if ((t - 1) % R == 0) check("tear_new", 32'(if1.seg), 32'(new_segs[((t-1)/R)*8 +: 8]));
    end
    $display("tearing: frame kept 3A7F, next frame 1234");

    // Out-of-range select on the three-channel instance holds the channel.
    check("oor_initial", 32'(if3.cur_ch), 32'd2);
    if3.sel = 3;
    for (int f = 0; f < 4; f++) begin
      wait_boundary();
      check("oor_hold", 32'(if3.cur_ch), 32'd2);
    end
    $display("out-of-range select: cur_ch held at %0d", if3.cur_ch);

    // Auto mode from channel 3: advance every two frames.
    if1.sel = 3;
    wait_boundary();
    check("auto_start", 32'(if1.cur_ch), 32'd3);
    if1.auto_mode = 1;
    for (int t = 1; t <= 65; t++) begin
      tick();
      if (t == 31) check("auto_hold3", 32'(if1.cur_ch), 32'd3);
      if (t == 32) check("auto_to0",   32'(if1.cur_ch), 32'd0);
      if (t == 33) check("auto_seg0",  32'(if1.seg),    32'hB0);
      if (t == 63) check("auto_hold0", 32'(if1.cur_ch), 32'd0);
      if (t == 64) check("auto_to1",   32'(if1.cur_ch), 32'd1);
      if (t == 65) check("auto_seg1",  32'(if1.seg),    32'hF8);
    end
    if1.auto_mode = 0;
    if1.sel = 0;
    $display("auto mode: 3 -> 0 -> 1 every 32 cycles");

    // Debounce: bouncing, clean press, release, reset mid-count.
    for (int t = 0; t < 30; t++) begin
      if (t % 3 == 0) if1.step_btn = ~if1.step_btn;
      tick();
      check("bounce_nopulse", 32'(if1.step_pulse), 32'd0);
    end
    if1.step_btn = 0;
    repeat (5) tick();
    if1.step_btn = 1;
    for (int t = 1; t <= 20; t++) begin
      tick();
      check("press_pulse", 32'(if1.step_pulse), 32'(t == 11));
    end
    if1.step_btn = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      check("release_nopulse", 32'(if1.step_pulse), 32'd0);
    end
    if1.step_btn = 1;
    repeat (6) tick();
    Reset = 1;
    if1.step_btn = 0;
    repeat (2) tick();
    Reset = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      check("reset_abort_nopulse", 32'(if1.step_pulse), 32'd0);
    end
    $display("debounce: bounce/press/release/reset sequences done");

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) set_ch(int'($urandom_range(0, 3)), 16'($urandom));
      if ($urandom_range(0, 39) == 0) if1.sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) if1.auto_mode = ~if1.auto_mode;
      if ($urandom_range(0, 11) == 0) if1.step_btn = ~if1.step_btn;
      Reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    Reset = 0;
    $display("random: 3000 cycles compared with model");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/debug_display_scan.md
Name: debug_display_scan

Overview:
- Parametrised debug-display front end for the single-cycle CPU board.
- Time-multiplexes NUM_CH selectable channels onto a DIGITS-wide active-low 7-segment display. Each channel is a pair of VAL_W-bit values, for example PC/next_PC or rs/ReadData1.
- Adds over the previous display path:
  - frame-coherent snapshotting (no tearing);
  - auto-cycle mode;
  - a built-in debounced single-step pulse generator for the CPU clock/enable.

Parameters:
- NUM_CH, 4, number of channels; must be ≥1.
- SEL_W, 2, width of the channel select; must satisfy 2^SEL_W ≥ NUM_CH.
- VAL_W, 8, width of each value; must be a multiple of 4.
- DIGITS, 2*VAL_W/4, digit count; fixed relation, not user-overridable.
- REFRESH_DIV, 100000, clock cycles each digit is driven.
- AUTO_FRAMES, 500, full scan frames per channel in auto mode.
- DEBOUNCE_CYC, 1000000, cycles step_btn must be stable before it is accepted.

Ports:
- clock, in, 1: system clock.
- Reset, in, 1: synchronous, active-high reset.
- ch_data, in, NUM_CH*2*VAL_W: channel c occupies bits [(c+1)*2*VAL_W-1 : c*2*VAL_W]. Within a channel, the upper VAL_W bits are in1 (left) and the lower VAL_W bits are in2 (right).
- sel, in, SEL_W: manual channel select (switches).
- auto_mode, in, 1: 1 = cycle channels automatically.
- step_btn, in, 1: raw, asynchronous push button.
- step_pulse, out, 1: one-cycle pulse on each accepted press.
- cur_ch, out, SEL_W: channel currently displayed.
- an, out, DIGITS: digit enables, active-low. an[DIGITS-1] is the leftmost digit.
- seg, out, 8: segments, active-low, ordered {dp,g,f,e,d,c,b,a}.

Behaviour:
- Reset values (all synchronous):
  - refresh counter 0, digit_idx 0, frame counter 0;
  - cur_ch 0, snapshot 0, step_pulse 0;
  - an all ones, seg 8'hFF.
  - Reset mid-frame or mid-debounce aborts the operation in progress; nothing is retained.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1.
  - At the terminal count, digit_idx increments and wraps from DIGITS-1 to 0.
- Frame boundary: the cycle where digit_idx wraps to 0. On that cycle:
  - cur_ch updates, per the mode rules below.
  - snapshot loads from ch_data for the new cur_ch value, in the same cycle.
- Display:
  - Digit i shows nibble i of snapshot (nibble 0 = LSN of in2).
  - an = ~(1<<digit_idx) and seg = hex code of the nibble. Both are registered, so they follow digit_idx with one cycle of latency.
  - Hex codes, active-low with dp off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
  - dp (seg[7]) is driven 0 on digit DIGITS/2, separating in1 from in2.
  - The first cycle after reset shows digit 0 of snapshot 0, i.e. an=...1110, seg=C0.
- Manual mode (auto_mode=0):
  - cur_ch ← sel at each frame boundary.
  - If sel ≥ NUM_CH, cur_ch holds its previous value.
- Auto mode (auto_mode=1):
  - The frame counter counts frame boundaries. At AUTO_FRAMES it clears and cur_ch increments, wrapping from NUM_CH-1 to 0.
  - The 0→1 transition of auto_mode clears the frame counter; cycling resumes from the current cur_ch.
  - A 1→0 transition takes sel at the next frame boundary.
  - auto_mode is sampled every cycle, with no synchroniser. Switches are treated as quasi-static.
- Debouncer:
  - step_btn passes through a 2-FF synchroniser to give s.
  - If s ≠ stable, a counter increments; any cycle with s == stable clears it.
  - When the counter reaches DEBOUNCE_CYC-1, stable ← s and the counter clears.
  - step_pulse = 1 for exactly the one cycle after stable goes 0→1.
  - Release (1→0) produces no pulse.
  - Latency from a clean press to the pulse is 2 + DEBOUNCE_CYC + 1 cycles.
- Simultaneous events:
  - A frame boundary coinciding with an auto advance applies the advance first, and snapshot loads the new channel.
  - Reset dominates everything.

Test Plan:
(All cases use NUM_CH=4, VAL_W=8, REFRESH_DIV=4, AUTO_FRAMES=2, DEBOUNCE_CYC=8.)
- Reset scan: release Reset with ch_data=0. Required: an cycles 1110→1101→1011→0111, each held 4 cycles, then repeats. seg=C0 on all digits except digit 2, which shows 40 (dp lit).
- Manual select:
  - Setup: channel 2 = {8'h3A, 8'h7F}, sel=2.
  - After the next frame boundary, cur_ch=2, and digits 0..3 show F, 7, A, 3 (8E, F8, 08, B0; dp lit on digit 2).
  - Changing sel mid-frame leaves the display unchanged until the boundary.
- Tearing: change channel 2 data to 16'h1234 at digit 1 of a frame. Required: that frame still shows 3A7F; the next frame shows 1234.
- Out-of-range select: with NUM_CH=3, set sel=3. Required: cur_ch holds 2 indefinitely.
- Auto mode: set auto_mode=1 with cur_ch=3. Required: cur_ch becomes 0 after 2 boundaries (32 cycles), then 1 after another 32; snapshot follows each change.
- Debounce:
  - Bounce step_btn 0/1 every 3 cycles for 30 cycles: no step_pulse.
  - Hold at 1: exactly one 1-cycle pulse, 11 cycles after the hold begins.
  - Release: no pulse.
  - Reset asserted mid-count: no pulse.
